pcpi_nibble_loader: RTL and testbench

//  Host-side front end of the PCPI coprocessor on the TinyTapeout pins.
//  - Assembles a 32-bit instruction from eight 4-bit nibbles strobed in on the pins.
//  - Issues the instruction on the PCPI handshake.
//  - Captures the coprocessor result and returns it nibble-serially on request.
//  - Sits directly upstream of fused_matrix_mult_pcpi.

---
 rtl/pcpi_loader_pkg.sv | 20 ++
 rtl/pin_edge_sync.sv | 47 ++++
 rtl/pcpi_nibble_loader.sv | 145 ++++++++++++++
 tb/tb_pcpi_nibble_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpi_loader_pkg.sv
// Shared types and helpers for the PCPI nibble loader.
package pcpi_loader_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        StLoad    = 2'd0,
        StIssue   = 2'd1,
        StReadout = 2'd2
    } state_e;

    // Counter width for values 0..v-1; never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/pin_edge_sync.sv
// Synchronizes an asynchronous pin strobe and emits a one-cycle pulse on its rising edge.
module pin_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   prev_q, prev_d;
    logic                   armed_q, armed_d;
    logic                   pulse_q, pulse_d;
    logic                   level;

    // Edges are only armed once a genuine low has been sampled after reset, so a pin
    // held high through reset never produces a pulse.
    always_comb begin
        level   = sync_q[SYNC_STAGES-1];
        sync_d  = {sync_q[SYNC_STAGES-2:0], pin_i};
        fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
        prev_d  = level;
        armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~level);
        pulse_d = level & ~prev_q & armed_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fill_q  <= fill_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/pcpi_nibble_loader.sv
// Host front end of the PCPI coprocessor: assembles an instruction from pin nibbles,
// issues it on PCPI and returns the result nibble-serially.
module pcpi_nibble_loader #(
    parameter int unsigned NIBBLES     = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   seg_strobe,
    input  logic [3:0]             seg_data,
    output logic                   seg_ack,
    input  logic                   res_strobe,
    output logic [3:0]             res_data,
    output logic                   res_valid,
    output logic                   pcpi_valid,
    output logic [4*NIBBLES-1:0]   pcpi_insn,
    input  logic                   pcpi_ready,
    input  logic                   pcpi_wr,
    input  logic [4*NIBBLES-1:0]   pcpi_rd,
    input  logic                   pcpi_wait,
    output logic                   busy,
    output logic                   err
);

    import pcpi_loader_pkg::*;

    localparam int unsigned W     = NIBBLE_W * NIBBLES;
    localparam int unsigned CNT_W = clog2(NIBBLES);
    localparam int unsigned TMO_W = clog2(TIMEOUT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [W-1:0]     insn_q, insn_d;
    logic [W-1:0]     rbuf_q, rbuf_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             seg_edge, res_edge;

    pin_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_seg_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .pin_i   (seg_strobe),
        .pulse_o (seg_edge)
    );

    pin_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_res_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .pin_i   (res_strobe),
        .pulse_o (res_edge)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        tmo_d   = tmo_q;
        insn_d  = insn_q;
        rbuf_d  = rbuf_q;
        ack_d   = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            StLoad: begin
                if (seg_edge) begin
                    insn_d[NIBBLE_W*cnt_q +: NIBBLE_W] = seg_data;
                    ack_d = 1'b1;
                    if (cnt_q == '0) err_d = 1'b0;
                    if (cnt_q == CNT_W'(NIBBLES - 1)) begin
                        cnt_d   = '0;
                        state_d = StIssue;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StIssue: begin
                // A ready in the same cycle as the timeout wins.
                if (pcpi_ready) begin
                    tmo_d = '0;
                    if (pcpi_wr) begin
                        rbuf_d  = pcpi_rd;
                        rcnt_d  = '0;
                        state_d = StReadout;
                    end else begin
                        state_d = StLoad;
                    end
                end else if (pcpi_wait) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    tmo_d   = '0;
                    err_d   = 1'b1;
                    state_d = StLoad;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StReadout: begin
                if (res_edge) begin
                    rbuf_d = rbuf_q >> NIBBLE_W;
                    if (rcnt_q == CNT_W'(NIBBLES - 1)) begin
                        rcnt_d  = '0;
                        state_d = StLoad;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StLoad;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            tmo_q   <= '0;
            insn_q  <= '0;
            rbuf_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            tmo_q   <= tmo_d;
            insn_q  <= insn_d;
            rbuf_q  <= rbuf_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign seg_ack    = ack_q;
    assign pcpi_insn  = insn_q;
    assign pcpi_valid = (state_q == StIssue);
    assign res_valid  = (state_q == StReadout);
    assign res_data   = res_valid ? rbuf_q[NIBBLE_W-1:0] : '0;
    assign busy       = (state_q != StLoad);
    assign err        = err_q;

endmodule

// File: tb/tb_pcpi_nibble_loader.sv
// Directed and randomized checks of pcpi_nibble_loader against a transaction-level model.
module tb_pcpi_nibble_loader;

    localparam int unsigned NIB = 8;
    localparam int unsigned TMO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        seg_strobe = 1'b0;
    logic [3:0]  seg_data = 4'h0;
    logic        res_strobe = 1'b0;
    logic        pcpi_ready = 1'b0;
    logic        pcpi_wr = 1'b0;
    logic [31:0] pcpi_rd = 32'h0;
    logic        pcpi_wait = 1'b0;
    logic        seg_ack, res_valid, pcpi_valid, busy, err;
    logic [3:0]  res_data;
    logic [31:0] pcpi_insn;

    int checks = 0;
    int errors = 0;
    int valid_run = 0;
    int last_run = 0;

    pcpi_nibble_loader #(
        .NIBBLES     (NIB),
        .SYNC_STAGES (2),
        .TIMEOUT     (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_strobe (seg_strobe),
        .seg_data   (seg_data),
        .seg_ack    (seg_ack),
        .res_strobe (res_strobe),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_ready (pcpi_ready),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Length of the most recent completed pcpi_valid run, in sampled cycles.
    always @(negedge clk) begin
        if (pcpi_valid) begin
            valid_run <= valid_run + 1;
        end else if (valid_run != 0) begin
            last_run  <= valid_run;
            valid_run <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_seg(input logic [3:0] d, output int acks, output logic err_at,
                            output logic valid_at);
        acks = 0;
        err_at = 1'bx;
        valid_at = 1'bx;
        seg_data = d;
        seg_strobe = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (seg_ack) begin
                acks++;
                err_at = err;
                valid_at = pcpi_valid;
            end
            if (i == 5) seg_strobe = 1'b0;
        end
    endtask

    task automatic pulse_res();
        res_strobe = 1'b1;
        repeat (6) @(negedge clk);
        res_strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Model: nibble i of the word goes to insn[4i+:4]; the issue starts with the last ack.
    task automatic load_word(input logic [31:0] w);
        int   acks;
        logic e, v;
        for (int i = 0; i < NIB; i++) begin
            send_seg(w[4*i +: 4], acks, e, v);
            check($sformatf("ack_n%0d", i), acks, 1);
            if (i == 0) check("err_clr_first", e, 0);
            check($sformatf("valid_at_ack_n%0d", i), v, (i == NIB - 1));
        end
        check("insn", pcpi_insn, w);
        check("valid_issue", pcpi_valid, 1);
        check("busy_issue", busy, 1);
    endtask

    task automatic respond(input logic wr, input logic [31:0] rd);
        pcpi_ready = 1'b1;
        pcpi_wr = wr;
        pcpi_rd = rd;
        @(negedge clk);
        pcpi_ready = 1'b0;
        pcpi_wr = 1'b0;
        pcpi_rd = $urandom;
        check("valid_drop", pcpi_valid, 0);
        check("res_valid_after_ready", res_valid, wr);
        check("busy_after_ready", busy, wr);
    endtask

    task automatic readout(input logic [31:0] rd);
        for (int i = 0; i < NIB; i++) begin
            check($sformatf("res_valid_n%0d", i), res_valid, 1);
            check($sformatf("res_data_n%0d", i), res_data, rd[4*i +: 4]);
            pulse_res();
        end
        check("res_valid_end", res_valid, 0);
        check("res_data_end", res_data, 0);
        check("busy_end", busy, 0);
    endtask

    initial begin
        int          acks;
        logic        e, v;
        logic [31:0] w, rd;

        // Reset with the nibble strobe held high.
        seg_strobe = 1'b1;
        seg_data = 4'h5;
        repeat (3) @(negedge clk);
        check("rst_insn", pcpi_insn, 0);
        check("rst_res_data", res_data, 0);
        check("rst_flags", {seg_ack, res_valid, pcpi_valid, busy, err}, 0);
        rst_n = 1'b1;
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (seg_ack) acks++;
        end
        check("held_strobe_ack", acks, 0);
        check("held_strobe_insn", pcpi_insn, 0);
        seg_strobe = 1'b0;
        repeat (4) @(negedge clk);

        // Nibbles 1..8, then a write-back of DEADBEEF.
        load_word(32'h8765_4321);
        repeat (2) @(negedge clk);
        respond(1'b1, 32'hDEAD_BEEF);
        readout(32'hDEAD_BEEF);

        // Long wait, stray nibble, bursty wait, then ready without write-back.
        load_word($urandom);
        w = pcpi_insn;
        pcpi_wait = 1'b1;
        send_seg($urandom, acks, e, v);
        check("issue_seg_ack", acks, 0);
        check("issue_insn_held", pcpi_insn, w);
        repeat (2000) @(negedge clk);
        check("wait_valid", pcpi_valid, 1);
        check("wait_err", err, 0);
        for (int k = 0; k < 4; k++) begin
            pcpi_wait = 1'b0;
            repeat ($urandom_range(13, 0)) @(negedge clk);
            pcpi_wait = 1'b1;
            repeat ($urandom_range(5, 1)) @(negedge clk);
        end
        check("gaps_valid", pcpi_valid, 1);
        respond(1'b0, $urandom);
        pcpi_wait = 1'b0;
        repeat (12) @(negedge clk);
        check("nowr_res_valid", res_valid, 0);
        check("nowr_err", err, 0);

        // Timeout: valid holds for exactly TMO cycles, then err sticks until the next load.
        load_word($urandom);
        repeat (TMO + 4) @(negedge clk);
        check("tmo_run", last_run, TMO);
        check("tmo_valid", pcpi_valid, 0);
        check("tmo_err", err, 1);
        check("tmo_busy", busy, 0);
        repeat (20) @(negedge clk);
        check("tmo_err_sticky", err, 1);
        rd = $urandom;
        load_word($urandom);
        check("err_after_load", err, 0);
        respond(1'b1, rd);
        readout(rd);

        // Reset after 5 nibbles; only the new nibbles A,9,..,3 form the instruction.
        for (int i = 0; i < 5; i++) begin
            send_seg($urandom, acks, e, v);
            check($sformatf("partial_ack_n%0d", i), acks, 1);
        end
        check("partial_no_issue", busy, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_insn", pcpi_insn, 0);
        load_word(32'h3456_789A);
        rd = $urandom;
        respond(1'b1, rd);
        send_seg($urandom, acks, e, v);
        check("readout_seg_ack", acks, 0);
        check("readout_res_data_held", res_data, rd[3:0]);
        readout(rd);

        // Asynchronous drop of pcpi_valid, then a result strobe while loading.
        load_word($urandom);
        rst_n = 1'b0;
        #1;
        check("async_valid", pcpi_valid, 0);
        check("async_insn", pcpi_insn, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        pulse_res();
        check("load_res_strobe", {res_valid, busy}, 0);

        // Randomized transactions.
        for (int t = 0; t < 3; t++) begin
            w = $urandom;
            rd = $urandom;
            load_word(w);
            pcpi_wait = 1'b1;
            repeat ($urandom_range(40, 1)) @(negedge clk);
            pcpi_wait = 1'b0;
            respond(1'b1, rd);
            readout(rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
